edge_event_tx: RTL and testbench

- Transmit-side partner of the dual-edge detector.
- Converts single-cycle event strobes into transitions on a serial line, so that a dual-edge detector at the far end reports one edge per event.
- Queues bursts of events in a saturating pending counter.
- Enforces a minimum dwell between transitions so that no edge is lost or merged at the receiver.

---
 rtl/edge_event_tx.sv | 130 +++++++++++++
 tb/tb_edge_event_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_tx.sv
// Event-strobe to line-transition encoder with saturating backlog and minimum dwell.
// Define EDGE_TX_RZ_EN for return-to-zero pulses instead of NRZ toggles.
module edge_event_tx #(
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             event_i,
  input  logic             clr_ovf_i,
  output logic             line_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o
);

  localparam int unsigned HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

`ifdef EDGE_TX_RZ_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, HOLD_LO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  pending_d;
  logic              line_d;
  logic              overflow_d;
  logic              fire;
  logic              accept;
  logic              drop;
  logic              hold_done;
  logic              has_pend;
  logic              full;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      line_o     <= 1'b0;
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      line_o     <= line_d;
      pending_o  <= pending_d;
      overflow_o <= overflow_d;
    end
  end

  // Next-state, dwell timing, backlog accounting and overflow flag
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    line_d     = line_o;
    pending_d  = pending_o;
    overflow_d = overflow_o;
    fire       = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    hold_done  = (hold_q == '0);
    has_pend   = (pending_o != '0);
    full       = (pending_o == CNT_MAX);

    unique case (state_q)
      IDLE: begin
        if (has_pend) fire = 1'b1;
      end
      HOLD: begin
        if (!hold_done) begin
          hold_d = hold_q - HOLD_W'(1);
`ifdef EDGE_TX_RZ_EN
        end else begin
          // High half of the pulse is over; dwell low before the next event
          line_d  = 1'b0;
          hold_d  = HOLD_LOAD;
          state_d = HOLD_LO;
        end
      end
      HOLD_LO: begin
        if (!hold_done) begin
          hold_d = hold_q - HOLD_W'(1);
`endif
        end else if (has_pend) begin
          fire = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

    if (fire) begin
`ifdef EDGE_TX_RZ_EN
      line_d = 1'b1;
`else
      line_d = ~line_o;
`endif
      hold_d  = HOLD_LOAD;
      state_d = HOLD;
    end

    // A fire frees one slot, so a saturated counter can still take the event
    accept = event_i & (~full | fire);
    drop   = event_i & full & ~fire;

    if (accept && !fire) begin
      pending_d = pending_o + CNT_W'(1);
    end else if (!accept && fire) begin
      pending_d = pending_o - CNT_W'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  assign busy_o = (state_q != IDLE) || (pending_o != '0);

endmodule

// File: tb/tb_edge_event_tx.sv
// Randomised bench for edge_event_tx (NRZ build) against a timestamp-based reference model.
module tb_edge_event_tx;

  localparam int unsigned MIN_HOLD = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          CAP      = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             event_i;
  logic             clr_ovf_i;
  logic             line_o;
  logic             busy_o;
  logic [CNT_W-1:0] pending_o;
  logic             overflow_o;

  edge_event_tx #(.MIN_HOLD(MIN_HOLD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .event_i    (event_i),
    .clr_ovf_i  (clr_ovf_i),
    .line_o     (line_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: backlog count plus the edge index of the last transition
  int m_edge  = 0;
  int m_lastf = -1000;
  int m_pend  = 0;
  bit m_line  = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_setwin = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (m_pend != 0) || (m_edge - m_lastf < int'(MIN_HOLD));
  endfunction

  task automatic model_reset();
    m_lastf = -1000;
    m_pend  = 0;
    m_line  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit fire;
    bit drop;
    m_edge++;
    fire = (m_pend > 0) && (m_edge - m_lastf >= int'(MIN_HOLD));
    drop = event_i && (m_pend == CAP) && !fire;
    if (event_i && !drop) m_pend++;
    if (fire) begin
      m_pend--;
      m_line  = ~m_line;
      m_lastf = m_edge;
    end
    m_setwin = drop && clr_ovf_i;
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf_i) m_ovf = 1'b0;
  endtask

  task automatic compare(input string pfx);
    check({pfx, "line"}, 32'(line_o), 32'(m_line));
    check({pfx, "pending"}, 32'(pending_o), 32'(m_pend));
    check({pfx, "overflow"}, 32'(overflow_o), 32'(m_ovf));
    check({pfx, "busy"}, 32'(busy_o), 32'(m_busy()));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    compare("");
    if (m_setwin) check("set_wins", 32'(overflow_o), 32'd1);
  endtask

  // Asynchronous reset asserted between edges, with an event pulse while held
  task automatic async_reset();
    #3 reset_n = 1'b0;
    model_reset();
    #1 compare("rst_");
    event_i = 1'b1;
    @(posedge clk);
    #1 event_i = 1'b0;
    compare("rst_hold_");
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  int peak;
  int toggles;
  int exp_toggles;
  bit prev_line;
  int rate;

  initial begin
    reset_n   = 1'b0;
    event_i   = 1'b0;
    clr_ovf_i = 1'b0;
    model_reset();

    // Reset: event pulse while held low must be ignored
    repeat (2) @(posedge clk);
    #1 event_i = 1'b1;
    @(posedge clk);
    #1 event_i = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1 compare("reset_");

    // Single event: latency and dwell
    repeat (3) step();
    event_i = 1'b1;
    step();
    event_i = 1'b0;
    check("lat_pending", 32'(pending_o), 32'd1);
    check("lat_line_before", 32'(line_o), 32'd0);
    step();
    check("lat_line_after", 32'(line_o), 32'd1);
    repeat (8) step();
    check("single_idle_busy", 32'(busy_o), 32'd0);

    // Burst of three strobes
    event_i = 1'b1;
    repeat (3) step();
    event_i = 1'b0;
    repeat (14) step();
    check("burst_end_line", 32'(line_o), 32'd0);
    check("burst_end_busy", 32'(busy_o), 32'd0);

    // Saturation: enter HOLD, then hold event_i long enough to fill the queue
    event_i = 1'b1;
    step();
    step();
    peak = 0;
    repeat (30) begin
      step();
      if (int'(pending_o) > peak) peak = int'(pending_o);
    end
    event_i = 1'b0;
    check("sat_peak", 32'(peak), 32'(CAP));
    check("sat_overflow", 32'(overflow_o), 32'd1);
    exp_toggles = m_pend;
    toggles = 0;
    prev_line = line_o;
    repeat (80) begin
      step();
      if (line_o != prev_line) toggles++;
      prev_line = line_o;
    end
    check("sat_drain_toggles", 32'(toggles), 32'(exp_toggles));
    check("sat_ovf_sticky", 32'(overflow_o), 32'd1);
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Set-wins: clear held while the saturated queue keeps dropping events
    event_i = 1'b1;
    repeat (28) step();
    clr_ovf_i = 1'b1;
    repeat (8) step();
    event_i   = 1'b0;
    clr_ovf_i = 1'b0;
    repeat (80) step();

    // Reset mid-burst with five events queued
    event_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_pend == 5 && m_busy()) break;
    end
    event_i = 1'b0;
    check("midburst_pending", 32'(pending_o), 32'd5);
    async_reset();
    repeat (20) step();
    check("post_reset_line", 32'(line_o), 32'd0);

    // Randomised traffic with varying load, rare clears and rare resets
    rate = 20;
    for (int i = 0; i < 1200; i++) begin
      if (i % 60 == 0) rate = int'($urandom_range(0, 100));
      event_i   = ($urandom_range(0, 99) < rate);
      clr_ovf_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) begin
        event_i   = 1'b0;
        clr_ovf_i = 1'b0;
        async_reset();
      end else begin
        step();
      end
    end
    event_i   = 1'b0;
    clr_ovf_i = 1'b0;
    repeat (80) step();
    check("final_busy", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
